// File: rtl/wb_slave_translator.sv
// ---------------------------------------------------------------------------
// wb_slave_translator
//
// Wishbone classic slave that converts every single-beat Wishbone access into
// one request on a req / wdata / rdata valid-ready stream interface. Only one
// access is in flight at a time and every request has req_len = 1.
//
// Optional feature (compile-time macro): WB_ERR_EN
//   Adds wb_err_o. Accesses whose byte address falls outside the window
//   (ADDR_BASE / ADDR_MASK) are answered with a one-cycle error and never
//   reach the stream side.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   wb_cyc_i, wb_stb_i     Wishbone cycle / strobe
//   wb_we_i, wb_sel_i      write enable, byte lane selects
//   wb_adr_i, wb_dat_i     word address (byte addr [31:2]), write data
//   wb_dat_o, wb_ack_o     read data, acknowledge
//   wb_err_o               error acknowledge (WB_ERR_EN only)
//   req_valid/ready        request handshake
//   req_we/len/mask/addr   request payload
//   wdata_valid/ready      write-data handshake, wdata payload
//   rdata_valid/ready      read-data handshake, rdata payload
// ---------------------------------------------------------------------------
module wb_slave_translator #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [29:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
`ifdef WB_ERR_EN
   output logic        wb_err_o,
`endif
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [2:0]  req_len,
   output logic [3:0]  req_mask,
   output logic [31:0] req_addr,
   output logic        wdata_valid,
   input  logic        wdata_ready,
   output logic [31:0] wdata,
   input  logic        rdata_valid,
   output logic        rdata_ready,
   input  logic [31:0] rdata
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_ACK, S_ERR} state_t;

   state_t state_q, state_d;

   logic req_done_q, wd_done_q;
   logic start, addr_hit;
   logic req_hs, wd_hs, rd_hs;
   logic req_fin, wd_fin;

   assign start  = wb_cyc_i && wb_stb_i && !wb_ack_o;
   assign req_hs = req_valid && req_ready;
   assign wd_hs  = wdata_valid && wdata_ready;
   assign rd_hs  = rdata_ready && rdata_valid;

   // A handshake counts as finished if it happened earlier or happens now.
   // Reads never raise wdata_valid, so their write-data side is trivially done.
   assign req_fin = req_done_q || req_hs;
   assign wd_fin  = wd_done_q || wd_hs || !req_we;

`ifdef WB_ERR_EN
   assign addr_hit = (({wb_adr_i, 2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
`else
   // The window parameters only matter when address checking is built in.
   logic unused_window;
   assign unused_window = ^{ADDR_BASE, ADDR_MASK};
   assign addr_hit      = 1'b1;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = addr_hit ? S_REQ : S_ERR;
         S_REQ: begin
            if (req_we) begin
               if (req_fin && wd_fin) state_d = S_ACK;
            end else if (req_fin) begin
               state_d = S_RD;
            end
         end
         S_RD:    if (rd_hs) state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs decoded from state ----------------
   // The ack/err is only given if the master is still in the cycle; a master
   // that gave up sees nothing, while the downstream side was already finished.
   always_comb begin
      wb_ack_o = (state_q == S_ACK) && wb_cyc_i && wb_stb_i;
`ifdef WB_ERR_EN
      wb_err_o = (state_q == S_ERR) && wb_cyc_i && wb_stb_i;
`endif
   end

   // ---------------- registered stream-side datapath ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_valid   <= 1'b0;
         req_we      <= 1'b0;
         req_len     <= 3'd0;
         req_mask    <= 4'd0;
         req_addr    <= 32'd0;
         wdata_valid <= 1'b0;
         wdata       <= 32'd0;
         rdata_ready <= 1'b0;
         wb_dat_o    <= 32'd0;
         req_done_q  <= 1'b0;
         wd_done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && addr_hit) begin
                  req_we      <= wb_we_i;
                  req_len     <= 3'd1;
                  req_mask    <= wb_sel_i;
                  req_addr    <= {wb_adr_i, 2'b00};
                  wdata       <= wb_dat_i;
                  req_valid   <= 1'b1;
                  wdata_valid <= wb_we_i;
                  req_done_q  <= 1'b0;
                  wd_done_q   <= 1'b0;
               end
            end
            S_REQ: begin
               if (req_hs) begin
                  req_valid  <= 1'b0;
                  req_done_q <= 1'b1;
               end
               if (wd_hs) begin
                  wdata_valid <= 1'b0;
                  wd_done_q   <= 1'b1;
               end
               if (state_d == S_RD) rdata_ready <= 1'b1;
            end
            S_RD: begin
               if (rd_hs) begin
                  wb_dat_o    <= rdata;
                  rdata_ready <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_slave_translator.sv
module tb_wb_slave_translator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [29:0] adr;
   logic [31:0] dat;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_len;
   logic [3:0]  req_mask;
   logic [31:0] req_addr;
   logic        wdata_valid, wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid, rdata_ready;
   logic [31:0] rdata;

   // Accesses are placed inside the decoded window; the window base only
   // matters when the error feature is built in.
`ifdef WB_ERR_EN
   localparam logic [31:0] BYTE_HI = 32'h8000_0000;
`else
   localparam logic [31:0] BYTE_HI = 32'h0000_0000;
   assign wb_err_o = 1'b0;
`endif
   localparam logic [29:0] WORD_HI = BYTE_HI[31:2];

   wb_slave_translator #(.ADDR_BASE(32'h8000_0000), .ADDR_MASK(32'hFFFF_0000)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
`ifdef WB_ERR_EN
      .wb_err_o(wb_err_o),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [29:0] adr;       // low word-address bits, OR-ed with WORD_HI
      logic [31:0] dat;
      int          rq;        // cycles req_ready is held low while req_valid is up
      int          wd;        // cycles wdata_ready is held low
      int          rd;        // cycles in RD before rdata_valid rises
      logic [31:0] rdat;
      int          drop;      // cycle at which the master abandons (0 = never)
      int          exp_ack;   // expected ack cycle, -1 = no ack
      logic [31:0] exp_addr;  // expected req_addr low part
   } vec_t;

   int          n_pass = 0, n_total = 0;
   logic [31:0] last_rd = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: cycle 0 samples stb, the request is up in cycle 1 and each
   // handshake fires once its ready is released. Writes ack the cycle after
   // the later handshake; reads enter RD the cycle after the request
   // handshake, capture after rd wait cycles, and ack one cycle later.
   function automatic int model_ack(input vec_t v);
      int done;
      done = v.we ? 1 + ((v.rq > v.wd) ? v.rq : v.wd) : 2 + v.rq + v.rd;
      return (v.drop != 0) ? -1 : done + 1;
   endfunction

   function automatic logic outs_any();
      return |{wb_dat_o, wb_ack_o, wb_err_o, req_valid, req_we, req_len, req_mask,
               req_addr, wdata_valid, wdata, rdata_ready};
   endfunction

   // Master + downstream responder for one access; called at a negedge with
   // the DUT idle. Cycle c is the clock period ending at posedge number c.
   task automatic run_access(input string nm, input vec_t v);
      int rq_hs = -1, wd_hs = -1, rd_hs = -1, ack_c = -1, acks = 0, done_c;
      bit stable = 1, rdr_ok = 1, fin = 0;
      logic [31:0] full_addr;
      full_addr = v.exp_addr | BYTE_HI;
      cyc = 1; stb = 1; we = v.we; sel = v.sel; adr = v.adr | WORD_HI; dat = v.dat;
      req_ready = 0; wdata_ready = 0; rdata_valid = 0; rdata = v.rdat;
      for (int c = 1; c < 60; c++) begin
         @(negedge clk);
         if (req_valid && {req_we, req_mask, req_addr, req_len} !== {v.we, v.sel, full_addr, 3'd1})
            stable = 0;
         if (wdata_valid && !(v.we && wdata === v.dat)) stable = 0;
         if (!v.we && rq_hs >= 0 && rd_hs < 0 && !rdata_ready) rdr_ok = 0;
         if (wb_ack_o) begin acks++; if (ack_c < 0) ack_c = c; end
         done_c = -1;
         if (v.we) begin
            if (rq_hs >= 0 && wd_hs >= 0) done_c = (rq_hs > wd_hs) ? rq_hs : wd_hs;
         end else done_c = rd_hs;
         if (done_c >= 0 && c == done_c + 1) begin
            cyc = 0; stb = 0; req_ready = 0; wdata_ready = 0; rdata_valid = 0;
            fin = 1;
            break;
         end
         if (v.drop != 0 && c == v.drop) begin cyc = 0; stb = 0; end
         req_ready   = (c >= 1 + v.rq);
         wdata_ready = (c >= 1 + v.wd);
         rdata_valid = (rq_hs >= 0) && (c >= rq_hs + 1 + v.rd) && (rd_hs < 0);
         if (req_valid && req_ready && rq_hs < 0) rq_hs = c;
         if (wdata_valid && wdata_ready && wd_hs < 0) wd_hs = c;
         if (rdata_valid && rdata_ready && rd_hs < 0) rd_hs = c;
      end
      chk({nm, "_finished"}, 32'(fin), 32'd1);
      chk({nm, "_ack_cycle"}, ack_c, v.exp_ack);
      chk({nm, "_ack_count"}, acks, (v.exp_ack < 0) ? 0 : 1);
      chk({nm, "_payload_stable"}, 32'(stable), 32'd1);
      if (v.we) begin
         chk({nm, "_req_hs_cycle"}, rq_hs, 1 + v.rq);
         chk({nm, "_wd_hs_cycle"}, wd_hs, 1 + v.wd);
         chk({nm, "_dat_o_held"}, wb_dat_o, last_rd);
      end else begin
         chk({nm, "_rdata_ready_wait"}, 32'(rdr_ok), 32'd1);
         chk({nm, "_rd_hs_cycle"}, rd_hs, 2 + v.rq + v.rd);
         chk({nm, "_dat_o"}, wb_dat_o, v.rdat);
         last_rd = v.rdat;
      end
      @(negedge clk);
   endtask

   vec_t tbl[7];
   vec_t rv;
   logic stray;

   initial begin
      tbl[0] = '{1'b1, 4'b0011, 30'h0000_0400, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0, 2, 32'h0000_1000};
      tbl[1] = '{1'b0, 4'b1111, 30'h0000_0010, 32'h0,         0, 0, 5, 32'h1234_5678, 0, 8, 32'h0000_0040};
      tbl[2] = '{1'b1, 4'b1100, 30'h0000_03FF, 32'hA5A5_0F0F, 3, 6, 0, 32'h0, 0, 8, 32'h0000_0FFC};
      tbl[3] = '{1'b0, 4'b0001, 30'h0000_0001, 32'h0,         0, 0, 0, 32'h0BAD_F00D, 0, 3, 32'h0000_0004};
      tbl[4] = '{1'b1, 4'b0000, 30'h0000_0020, 32'h5555_AAAA, 0, 0, 0, 32'h0, 0, 2, 32'h0000_0080};
      tbl[5] = '{1'b0, 4'b1111, 30'h0000_0030, 32'h0,         0, 0, 5, 32'hCAFE_F00D, 4, -1, 32'h0000_00C0};
      tbl[6] = '{1'b1, 4'b1010, 30'h0000_0100, 32'h0123_4567, 4, 0, 0, 32'h0, 0, 6, 32'h0000_0400};

      rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
      req_ready = 0; wdata_ready = 0; rdata_valid = 0; rdata = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs_zero", 32'(outs_any()), 32'd0);
      chk("reset_req_len", 32'(req_len), 32'd0);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_access($sformatf("vec%0d", i), tbl[i]);

      // Strobe held through the ack: next access is sampled the cycle after.
      cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = WORD_HI | 30'd8; dat = 32'h1111_2222;
      req_ready = 1; wdata_ready = 1;
      @(negedge clk);
      @(negedge clk); chk("b2b_ack1", 32'(wb_ack_o), 32'd1);
      @(negedge clk); chk("b2b_idle_gap", 32'(req_valid), 32'd0);
      @(negedge clk); chk("b2b_req2", 32'(req_valid), 32'd1);
      @(negedge clk); chk("b2b_ack2", 32'(wb_ack_o), 32'd1);
      cyc = 0; stb = 0; req_ready = 0; wdata_ready = 0;
      @(negedge clk);

      // Asynchronous reset while a request is pending.
      cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = WORD_HI | 30'd5; dat = 32'h7777_8888;
      @(negedge clk);
      @(negedge clk); chk("rst_mid_req_valid", 32'(req_valid), 32'd1);
      #2 rst_n = 0;
      #1 chk("rst_mid_async_zero", 32'(outs_any()), 32'd0);
      cyc = 0; stb = 0; req_ready = 1; wdata_ready = 1;
      @(negedge clk); rst_n = 1;
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         if (req_valid || wdata_valid || wb_ack_o) stray = 1;
      end
      chk("rst_no_stray", 32'(stray), 32'd0);
      req_ready = 0; wdata_ready = 0;
      last_rd = 32'd0;

      for (int i = 0; i < 20; i++) begin
         rv.we   = 1'($urandom_range(0, 1));
         rv.sel  = 4'($urandom);
         rv.adr  = 30'($urandom) & 30'h3FFF;
         rv.dat  = $urandom;
         rv.rq   = $urandom_range(0, 4);
         rv.wd   = $urandom_range(0, 4);
         rv.rd   = $urandom_range(0, 4);
         rv.rdat = $urandom;
         rv.drop = 0;
         rv.exp_addr = {rv.adr, 2'b00};
         rv.exp_ack  = model_ack(rv);
         run_access($sformatf("rnd%0d", i), rv);
      end

`ifdef WB_ERR_EN
      begin
         int errs = 0, err_c = -1, acks = 0;
         bit req_seen = 0, both = 0;
         cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 30'h0000_0004;
         req_ready = 1; wdata_ready = 1;
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (wb_err_o) begin errs++; if (err_c < 0) err_c = c; end
            if (wb_ack_o) acks++;
            if (wb_err_o && wb_ack_o) both = 1;
            if (req_valid) req_seen = 1;
            if (wb_err_o) begin cyc = 0; stb = 0; end
         end
         chk("err_count", errs, 1);
         chk("err_cycle", err_c, 1);
         chk("err_no_ack", acks, 0);
         chk("err_no_req", 32'(req_seen), 32'd0);
         chk("err_ack_exclusive", 32'(both), 32'd0);
         req_ready = 0; wdata_ready = 0;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_slave_translator.md
Name: wb_slave_translator

Overview:
- Wishbone classic slave that turns each single Wishbone access into one request on the req/wdata/rdata stream interface.
- This is the responder-side counterpart of the request-to-Wishbone master, so a Wishbone interconnect can drive any block that consumes the stream interface.
- One outstanding access at a time. Every access is a single beat (req_len = 1).

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the decoded window (used only with WB_ERR_EN).
- ADDR_MASK, 32'hFFFF_0000, byte-address bits compared against ADDR_BASE (used only with WB_ERR_EN).

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset. Clock is clk_i, reset is rst_ni, asynchronous and active-low.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_sel_i  in  4  byte lane selects.
- wb_adr_i  in  30  word address (byte address bits [31:2]).
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  access acknowledge.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_we  out  1  request is a write.
- req_len  out  3  burst length, constant 3'd1.
- req_mask  out  4  byte mask, copied from wb_sel_i.
- req_addr  out  32  byte address, {wb_adr_i, 2'b00}.
- wdata_valid  out  1  write data valid.
- wdata_ready  in  1  write data accepted.
- wdata  out  32  write data.
- rdata_valid  in  1  read data valid.
- rdata_ready  out  1  read data accepted.
- rdata  in  32  read data.

Behaviour:
- Reset (async, while rst_ni = 0): state = IDLE and all outputs = 0, including wb_dat_o, req_* and wdata. Reset mid-access abandons the access and drops any valid immediately; there is no completion.
- Handshakes:
  - A handshake occurs on a rising edge where valid && ready.
  - Once valid is high, it stays high and payload stays stable until the handshake.
- IDLE:
  - When wb_cyc_i && wb_stb_i && !wb_ack_o, latch we/sel/adr/dat into req_we/req_mask/req_addr/wdata.
  - Set req_valid = 1. Set wdata_valid = wb_we_i. Go to REQ.
- REQ:
  - The request and write-data handshakes are independent and may complete in the same or different cycles.
  - Done flags record each handshake; the matching valid is cleared on its handshake.
  - Write: go to ACK when both handshakes are done.
  - Read: go to RD once the request handshake is done.
- RD:
  - rdata_ready = 1.
  - On rdata_valid, capture rdata into wb_dat_o, drop rdata_ready, go to ACK.
- ACK:
  - wb_ack_o = 1 for exactly one cycle if wb_cyc_i && wb_stb_i are still high; otherwise no ack (aborted).
  - Go to IDLE.
  - wb_dat_o holds its value until the next read capture.
- Abort:
  - If wb_cyc_i falls during REQ or RD, the downstream transaction still completes, because handshakes are never withdrawn.
  - Read data is captured but not acked.
  - A new access is taken only after returning to IDLE.
- Latency, with all ready/valid inputs held at 1:
  - stb sampled in IDLE at cycle 0 gives req_valid in cycle 1.
  - Write: wb_ack_o in cycle 2.
  - Read: rdata captured at end of cycle 2, wb_ack_o in cycle 3.
- Back-to-back accesses: IDLE does not accept while wb_ack_o = 1, so a strobe held through the ack starts the next access in the following cycle.
- wb_sel_i = 0 is forwarded unchanged as req_mask = 0; it is not suppressed.

Optional Feature:
- Macro WB_ERR_EN.
- With WB_ERR_EN:
  - Adds output wb_err_o (1 bit, reset 0).
  - In IDLE, if ({wb_adr_i, 2'b00} & ADDR_MASK) != (ADDR_BASE & ADDR_MASK), nothing is issued downstream. Go to ERR.
  - ERR asserts wb_err_o for one cycle (subject to the same cyc/stb check as ACK), then returns to IDLE.
  - wb_ack_o and wb_err_o are never both 1.
- Without WB_ERR_EN: no wb_err_o port, no address check, and every access is forwarded.

Test Plan:
- Write, all ready = 1: adr 30'h0000_0400, sel 4'b0011, dat 32'hDEAD_BEEF.
  - -> One cycle with req_valid && wdata_valid, req_addr 32'h0000_1000, req_mask 4'b0011, req_len 1, wdata 32'hDEAD_BEEF.
  - -> wb_ack_o exactly 2 cycles after stb sampled.
- Read, req_ready = 1, rdata_valid asserted 5 cycles after the request handshake with rdata 32'h1234_5678.
  - -> rdata_ready high throughout the wait, wb_dat_o = 32'h1234_5678 with a single-cycle ack.
- Write with req_ready held 0 for 3 cycles and wdata_ready 0 for 6 cycles.
  - -> req_valid and wdata_valid stable until their own handshakes; ack only after the later one.
- Read where wb_cyc_i drops while in RD.
  - -> rdata still accepted, no wb_ack_o, next access starts cleanly.
- rst_ni pulsed low while in REQ with req_valid = 1.
  - -> All outputs 0 asynchronously; no stray handshake after release.
- WB_ERR_EN, ADDR_BASE 32'h8000_0000, ADDR_MASK 32'hFFFF_0000, access to 32'h0000_0010.
  - -> wb_err_o for 1 cycle, req_valid never asserted.
